// File: rtl/data_mem_responder_pkg.sv
// Shared data-memory constants, common with the processor top.
//   DMEM_BASE_ADDR   : byte address of data word 0
//   DMEM_DEPTH_WORDS : number of 32-bit words in the data memory
//   DMEM_LATENCY     : cycles from request capture to response
//   dmem_state_t     : responder FSM state encoding (2 bits)
package data_mem_responder_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1001_0000;
    localparam int          DMEM_DEPTH_WORDS = 256;
    localparam int          DMEM_LATENCY     = 2;

    // Wide enough for the largest legal latency of 15.
    localparam int          DMEM_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Data-memory storage: DEPTH_WORDS x 32 bits, synchronous write and
// synchronous read. The storage is not reset. The read register is
// reset to zero and only loads on i_re, so between reads it holds the
// last word read.
//   clk     : clock
//   rst     : async active-high reset (read register only)
//   i_we    : write enable, i_wdata -> mem[i_index]
//   i_re    : read enable, mem[i_index] -> o_rdata
//   i_index : word index
//   i_wdata : write data
//   o_rdata : registered read data
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder. Turns processor load/store strobes into a
// single delayed transaction against dmem_array and reports completion
// with a one-cycle dReady pulse (dError flags a rejected request).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a rising strobe; captures the request
//   ST_BUSY | latency down-counter running; access happens at zero
//   ST_RESP | dReady high for this one cycle, dError if rejected
//
//   clk        : clock, rising edge
//   rst        : async active-high reset
//   MemRead    : load strobe
//   MemWrite   : store strobe
//   dAddress   : byte address
//   dWriteData : store data
//   dReadData  : registered load data, holds last successful read
//   dReady     : one-cycle completion pulse
//   dError     : request rejected (valid only with dReady)
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int          LATENCY     = DMEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        dReady,
    output logic        dError
);

    localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0]           SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] LAT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t            r_state;
    dmem_state_t            w_state_next;
    logic [DMEM_CNT_W-1:0]  r_cnt;
    logic                   r_strobe_q;
    logic                   r_armed;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic                   r_rd;
    logic                   r_wr;
    logic                   r_err;

    logic                   w_strobe;
    logic                   w_req;
    logic                   w_fire;
    logic [31:0]            w_offset;
    logic                   w_valid;
    logic                   w_we;
    logic                   w_re;
    logic [IDX_W-1:0]       w_index;

    assign w_strobe = MemRead | MemWrite;

    // r_armed stays low after reset until a low strobe has been seen, so a
    // strobe that was already high across reset is not taken as a request.
    assign w_req = w_strobe & ~r_strobe_q & r_armed;

    assign w_fire = (r_state == ST_BUSY) && (r_cnt == '0);

    // Offset is only meaningful when addr >= BASE_ADDR; checking that first
    // keeps addresses below the base from wrapping into range.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_valid  = (r_addr[1:0] == 2'b00)
                    && (r_addr >= BASE_ADDR)
                    && (w_offset < SPAN)
                    && (r_rd ^ r_wr);
    assign w_index  = w_offset[IDX_W+1:2];

    assign w_we = w_fire & w_valid & r_wr;
    assign w_re = w_fire & w_valid & r_rd;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req)         w_state_next = ST_BUSY;
            ST_BUSY: if (r_cnt == '0)   w_state_next = ST_RESP;
            ST_RESP:                    w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_strobe_q <= 1'b0;
            r_armed    <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_strobe_q <= w_strobe;
            if (!w_strobe) begin
                r_armed <= 1'b1;
            end
            if ((r_state == ST_IDLE) && w_req) begin
                r_addr  <= dAddress;
                r_wdata <= dWriteData;
                r_rd    <= MemRead;
                r_wr    <= MemWrite;
                r_cnt   <= LAT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt   <= r_cnt - 1'b1;
            end
            if (w_fire) begin
                r_err <= ~w_valid;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_dmem_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_index (w_index),
        .i_wdata (r_wdata),
        .o_rdata (dReadData)
    );

    assign dReady = (r_state == ST_RESP);
    assign dError = (r_state == ST_RESP) & r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        dReady;
    logic        dError;

    int tests_run    = 0;
    int tests_failed = 0;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .dReady     (dReady),
        .dError     (dError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one strobe pulse and wait (bounded) for dReady.
    // lat = negedges from drive to observed dReady (0 = timed out);
    // with LATENCY 2 the expected value is 3.
    task automatic run_txn(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic err,
                           output logic ready_after);
        lat = 0;
        err = 1'b0;
        ready_after = 1'b0;
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        dAddress   = addr;
        dWriteData = data;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            if (dReady) begin
                lat = i;
                err = dError;
                break;
            end
        end
        @(negedge clk);
        ready_after = dReady | dError;
    endtask

    task automatic test_reset();
        tests_run++;
        if (dReady !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 0", dReady);
        end
        tests_run++;
        if (dError !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_error: got %b want 0", dError);
        end
        tests_run++;
        if (dReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h want 00000000", dReadData);
        end
    endtask

    task automatic test_write_read();
        int lat; logic err; logic aft;
        run_txn(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, lat, err, aft);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL wr_latency: got %0d want 3", lat);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_error: got %b want 0", err);
        end
        tests_run++;
        if (aft !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_single_pulse: got %b want 0", aft);
        end
        tests_run++;
        if (dReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL wr_rdata_hold: got %h want 00000000", dReadData);
        end
        run_txn(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d want 3", lat);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_error: got %b want 0", err);
        end
        tests_run++;
        if (dReadData !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL rd_data: got %h want deadbeef", dReadData);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic err; logic aft;
        run_txn(1'b0, 1'b1, 32'h1001_0000, 32'h0000_0001, lat, err, aft);
        run_txn(1'b0, 1'b1, 32'h1001_0002, 32'hFFFF_FFFF, lat, err, aft);
        tests_run++;
        if (lat !== 3 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_err: got lat=%0d err=%b want lat=3 err=1", lat, err);
        end
        run_txn(1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, err, aft);
        tests_run++;
        if (err !== 1'b0 || dReadData !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL misaligned_readback: got err=%b data=%h want err=0 data=00000001", err, dReadData);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic err; logic aft;
        run_txn(1'b1, 1'b0, 32'h1001_0400, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || err !== 1'b1 || dReadData !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL oor_past_end: got lat=%0d err=%b data=%h want lat=3 err=1 data=00000001", lat, err, dReadData);
        end
        run_txn(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || err !== 1'b1 || dReadData !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL oor_below_base: got lat=%0d err=%b data=%h want lat=3 err=1 data=00000001", lat, err, dReadData);
        end
        run_txn(1'b1, 1'b0, 32'h1001_03FC, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word_ok: got lat=%0d err=%b want lat=3 err=0", lat, err);
        end
    endtask

    task automatic test_both_strobes();
        int lat; logic err; logic aft;
        run_txn(1'b0, 1'b1, 32'h1001_000C, 32'h0000_0011, lat, err, aft);
        run_txn(1'b1, 1'b1, 32'h1001_000C, 32'h0000_0BAD, lat, err, aft);
        tests_run++;
        if (lat !== 3 || err !== 1'b1 || aft !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_strobes: got lat=%0d err=%b after=%b want lat=3 err=1 after=0", lat, err, aft);
        end
        run_txn(1'b1, 1'b0, 32'h1001_000C, 32'h0, lat, err, aft);
        tests_run++;
        if (dReadData !== 32'h0000_0011) begin
            tests_failed++;
            $display("FAIL both_no_write: got %h want 00000011", dReadData);
        end
    endtask

    task automatic test_held_strobe();
        int pulses = 0;
        int lat; logic err; logic aft;
        @(negedge clk);
        MemRead  = 1'b1;
        dAddress = 32'h1001_0004;
        repeat (10) begin
            @(negedge clk);
            if (dReady) pulses++;
        end
        MemRead = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dReady) pulses++;
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL held_strobe_pulses: got %0d want 1", pulses);
        end
        run_txn(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || dReadData !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL held_strobe_rearm: got lat=%0d data=%h want lat=3 data=deadbeef", lat, dReadData);
        end
    endtask

    task automatic test_reset_busy();
        int pulses = 0;
        int lat; logic err; logic aft;
        run_txn(1'b0, 1'b1, 32'h1001_0008, 32'h0000_0000, lat, err, aft);
        @(negedge clk);
        MemWrite   = 1'b1;
        dAddress   = 32'h1001_0008;
        dWriteData = 32'h1234_5678;
        @(negedge clk);
        MemWrite = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (dReadData !== 32'h0 || dReady !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got data=%h ready=%b want data=00000000 ready=0", dReadData, dReady);
        end
        repeat (2) begin
            @(negedge clk);
            if (dReady) pulses++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dReady) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_busy_ready: got %0d pulses want 0", pulses);
        end
        run_txn(1'b1, 1'b0, 32'h1001_0008, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || dReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_busy_nowrite: got lat=%0d data=%h want lat=3 data=00000000", lat, dReadData);
        end
    endtask

    task automatic test_strobe_across_reset();
        int pulses = 0;
        int lat; logic err; logic aft;
        @(negedge clk);
        MemRead  = 1'b1;
        dAddress = 32'h1001_0004;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dReady) pulses++;
        end
        MemRead = 1'b0;
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL held_across_reset: got %0d pulses want 0", pulses);
        end
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err, aft);
        tests_run++;
        if (lat !== 3 || dReadData !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL after_reset_read: got lat=%0d data=%h want lat=3 data=deadbeef", lat, dReadData);
        end
    endtask

    initial begin
        rst        = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        dAddress   = 32'h0;
        dWriteData = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_both_strobes();
        test_held_strobe();
        test_reset_busy();
        test_strobe_across_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
